// File: rtl/fifo_drain_tx_pkg.sv
`default_nettype none
// =============================================================================
// Module   : fifo_drain_tx_pkg
// Brief    : Shared types and constants for the FIFO drain / TX packetiser.
// Revision : 1.0 - initial release
// =============================================================================
package fifo_drain_tx_pkg;

    localparam int DRAIN_TX_N_LEN_BITS  = 2;
    localparam int DRAIN_TX_EXTRA_SLACK = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } t_drain_state;

    typedef logic [DRAIN_TX_N_LEN_BITS-1:0] t_len;

    // Beats downstream must still absorb after raising almostFull.
    function automatic int slack_beats(input int n_len_bits);
        return (1 << n_len_bits) + DRAIN_TX_EXTRA_SLACK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_drain_tx_if.sv
`default_nettype none
// =============================================================================
// Module   : fifo_drain_tx_if
// Brief    : FIFO read-side and TX channel signals of the drain block.
// Revision : 1.0 - initial release
// =============================================================================
interface fifo_drain_tx_if
    import fifo_drain_tx_pkg::*;
#(
    parameter int N_DATA_BITS = 512,
    parameter int N_LEN_BITS  = DRAIN_TX_N_LEN_BITS
);
    logic [N_LEN_BITS+N_DATA_BITS-1:0] fifo_first;
    logic                              fifo_notEmpty;
    logic                              fifo_deq;
    logic                              tx_almostFull;
    logic                              tx_valid;
    logic [N_DATA_BITS-1:0]            tx_data;
    logic                              tx_sop;
    logic                              tx_eop;

    // master is the drain block itself; slave is the FIFO + TX port side.
    modport master (
        input  fifo_first, fifo_notEmpty, tx_almostFull,
        output fifo_deq, tx_valid, tx_data, tx_sop, tx_eop
    );

    modport slave (
        output fifo_first, fifo_notEmpty, tx_almostFull,
        input  fifo_deq, tx_valid, tx_data, tx_sop, tx_eop
    );
endinterface
`default_nettype wire

// File: rtl/fifo_drain_tx_out_stage.sv
`default_nettype none
// =============================================================================
// Module   : fifo_drain_tx_out_stage
// Brief    : Registered valid/data/sop/eop beat stage for the TX channel.
// Revision : 1.0 - initial release
// =============================================================================
module fifo_drain_tx_out_stage #(
    parameter int N_DATA_BITS = 512
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   i_load,
    input  wire logic [N_DATA_BITS-1:0] i_data,
    input  wire logic                   i_sop,
    input  wire logic                   i_eop,
    output logic                        o_valid,
    output logic [N_DATA_BITS-1:0]      o_data,
    output logic                        o_sop,
    output logic                        o_eop
);
    logic                   r_valid;
    logic [N_DATA_BITS-1:0] r_data;
    logic                   r_sop;
    logic                   r_eop;

    // Framing bits are qualified by load so they never appear on an idle cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
        end else begin
            r_valid <= i_load;
            r_sop   <= i_load && i_sop;
            r_eop   <= i_load && i_eop;
            if (i_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sop   = r_sop;
    assign o_eop   = r_eop;
endmodule
`default_nettype wire

// File: rtl/fifo_drain_tx.sv
`default_nettype none
// =============================================================================
// Module   : fifo_drain_tx
// Brief    : Drains {len,data} FIFO entries as multi-beat TX packets; new
//            packets start only while the registered almostFull is low.
//            Optional counters: define FIFO_DRAIN_TX_STATS_EN.
// Revision : 1.0 - initial release
// =============================================================================
module fifo_drain_tx
    import fifo_drain_tx_pkg::*;
#(
    parameter int N_DATA_BITS = 512,
    parameter int N_LEN_BITS  = DRAIN_TX_N_LEN_BITS
) (
    input  wire logic       clk,
    input  wire logic       reset,
    fifo_drain_tx_if.master bus,
    output logic            idle
`ifdef FIFO_DRAIN_TX_STATS_EN
    ,
    output logic [31:0]     stat_pkts,
    output logic [31:0]     stat_stall_cycles
`endif
);
    localparam logic [N_LEN_BITS-1:0] c_LEN_ONE = N_LEN_BITS'(1);

    t_drain_state            r_state;
    logic [N_LEN_BITS-1:0]   r_beats_left;
    logic                    r_af_q;

    logic                    w_deq;
    logic                    w_sop;
    logic                    w_eop;
    logic [N_LEN_BITS-1:0]   w_len;
    logic [N_DATA_BITS-1:0]  w_data;

    assign w_len  = bus.fifo_first[N_DATA_BITS +: N_LEN_BITS];
    assign w_data = bus.fifo_first[N_DATA_BITS-1:0];

    // Resets high so nothing starts before downstream status has been sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_af_q <= 1'b1;
        end else begin
            r_af_q <= bus.tx_almostFull;
        end
    end

    // Once a packet has started it runs to completion regardless of almostFull.
    always_comb begin
        w_deq = 1'b0;
        w_sop = 1'b0;
        w_eop = 1'b0;
        case (r_state)
            IDLE: begin
                w_deq = bus.fifo_notEmpty && !r_af_q;
                w_sop = 1'b1;
                w_eop = (w_len == '0);
            end
            BURST: begin
                w_deq = bus.fifo_notEmpty;
                w_eop = (r_beats_left == c_LEN_ONE);
            end
            default: begin
                w_deq = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_beats_left <= '0;
        end else if (w_deq) begin
            case (r_state)
                IDLE: begin
                    if (w_len != '0) begin
                        r_beats_left <= w_len;
                        r_state      <= BURST;
                    end
                end
                BURST: begin
                    r_beats_left <= r_beats_left - c_LEN_ONE;
                    if (r_beats_left == c_LEN_ONE) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_deq = w_deq;
    assign idle         = (r_state == IDLE);

    fifo_drain_tx_out_stage #(
        .N_DATA_BITS (N_DATA_BITS)
    ) u_out_stage (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_deq),
        .i_data  (w_data),
        .i_sop   (w_sop),
        .i_eop   (w_eop),
        .o_valid (bus.tx_valid),
        .o_data  (bus.tx_data),
        .o_sop   (bus.tx_sop),
        .o_eop   (bus.tx_eop)
    );

`ifdef FIFO_DRAIN_TX_STATS_EN
    logic [31:0] r_stat_pkts;
    logic [31:0] r_stat_stall_cycles;

    // Stall = work waiting in IDLE but held off by downstream backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_pkts         <= '0;
            r_stat_stall_cycles <= '0;
        end else begin
            if (bus.tx_valid && bus.tx_eop) begin
                r_stat_pkts <= r_stat_pkts + 32'd1;
            end
            if ((r_state == IDLE) && bus.fifo_notEmpty && r_af_q) begin
                r_stat_stall_cycles <= r_stat_stall_cycles + 32'd1;
            end
        end
    end

    assign stat_pkts         = r_stat_pkts;
    assign stat_stall_cycles = r_stat_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_tx.sv
`default_nettype none
// =============================================================================
// Module   : tb_fifo_drain_tx
// Brief    : Directed self-checking bench for fifo_drain_tx with a packet-level
//            reference model. Stats checks active with FIFO_DRAIN_TX_STATS_EN.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fifo_drain_tx;
    localparam int DW = 512;
    localparam int LW = 2;

    typedef logic [DW-1:0] data_t;
    typedef struct {
        data_t data;
        logic  sop;
        logic  eop;
        int    cyc;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic idle;
`ifdef FIFO_DRAIN_TX_STATS_EN
    logic [31:0] stat_pkts;
    logic [31:0] stat_stall_cycles;
`endif

    fifo_drain_tx_if #(.N_DATA_BITS(DW), .N_LEN_BITS(LW)) bus ();

    fifo_drain_tx #(
        .N_DATA_BITS (DW),
        .N_LEN_BITS  (LW)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .idle  (idle)
`ifdef FIFO_DRAIN_TX_STATS_EN
        ,
        .stat_pkts         (stat_pkts),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [LW+DW-1:0] fq[$];
    obs_t             obs[$];
    bit               deq_seen = 1'b0;

    task automatic check(input string name, input data_t act, input data_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_notEmpty = (fq.size() != 0);
        bus.fifo_first    = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (deq_seen && fq.size() != 0) void'(fq.pop_front());
        drive_fifo();
    endtask

    task automatic push(input logic [LW-1:0] len, input data_t d);
        fq.push_back({len, d});
        drive_fifo();
    endtask

    // ---------------- packet-level reference model ----------------
    bit          m_known  = 1'b0;
    bit          m_in_pkt = 1'b0;
    int          m_rem    = 0;
    bit          m_afq    = 1'b1;
    bit          e_valid  = 1'b0;
    bit          e_sop    = 1'b0;
    bit          e_eop    = 1'b0;
    data_t       e_data   = '0;
    bit          e_deq;
    logic [31:0] m_pkts   = '0;
    logic [31:0] m_stall  = '0;
    int          hdr_len;

    always @(negedge clk) begin : p_compare
        e_deq = bus.fifo_notEmpty && (m_in_pkt || !m_afq);
        if (m_known) begin
            check("tx_valid", bus.tx_valid, e_valid);
            if (e_valid) begin
                check("tx_data", bus.tx_data, e_data);
                check("tx_sop", bus.tx_sop, e_sop);
                check("tx_eop", bus.tx_eop, e_eop);
            end
            check("fifo_deq", bus.fifo_deq, e_deq);
            check("idle", idle, !m_in_pkt);
`ifdef FIFO_DRAIN_TX_STATS_EN
            check("stat_pkts", stat_pkts, m_pkts);
            check("stat_stall_cycles", stat_stall_cycles, m_stall);
`endif
        end
        if (bus.tx_valid === 1'b1) obs.push_back('{bus.tx_data, bus.tx_sop, bus.tx_eop, cyc});
        deq_seen = (bus.fifo_deq === 1'b1);

        if (reset) begin
            m_known  = 1'b1;
            m_in_pkt = 1'b0;
            m_rem    = 0;
            m_afq    = 1'b1;
            e_valid  = 1'b0;
            e_sop    = 1'b0;
            e_eop    = 1'b0;
            m_pkts   = '0;
            m_stall  = '0;
        end else if (m_known) begin
            if (e_valid && e_eop) m_pkts = m_pkts + 32'd1;
            if (!m_in_pkt && bus.fifo_notEmpty && m_afq) m_stall = m_stall + 32'd1;
            e_valid = e_deq;
            if (e_deq) begin
                e_data = bus.fifo_first[DW-1:0];
                if (!m_in_pkt) begin
                    hdr_len  = int'(bus.fifo_first[DW +: LW]);
                    e_sop    = 1'b1;
                    e_eop    = (hdr_len == 0);
                    m_rem    = hdr_len;
                    m_in_pkt = (hdr_len != 0);
                end else begin
                    m_rem    = m_rem - 1;
                    e_sop    = 1'b0;
                    e_eop    = (m_rem == 0);
                    m_in_pkt = (m_rem != 0);
                end
            end
            m_afq = bus.tx_almostFull;
        end
    end

    // ---------------- directed stimulus ----------------
    int t;
    int base;
    int t_drop;

    initial begin
        bus.tx_almostFull = 1'b0;
        bus.fifo_first    = '0;
        bus.fifo_notEmpty = 1'b0;
        repeat (3) step();

        check("reset tx_valid", bus.tx_valid, 1'b0);
        check("reset tx_sop", bus.tx_sop, 1'b0);
        check("reset tx_eop", bus.tx_eop, 1'b0);
        check("reset tx_data", bus.tx_data, '0);
        check("reset idle", idle, 1'b1);
        reset = 1'b0;
        step();

        // Single-beat packet
        t = cyc; base = obs.size();
        push(2'd0, data_t'('hA5));
        repeat (4) begin
            step();
            check("T1 idle", idle, 1'b1);
        end
        check("T1 beats", data_t'(obs.size() - base), data_t'(1));
        check("T1 data", obs[base].data, data_t'('hA5));
        check("T1 sop", obs[base].sop, 1'b1);
        check("T1 eop", obs[base].eop, 1'b1);
        check("T1 latency", data_t'(obs[base].cyc), data_t'(t + 1));

        // Max-length packet; body len fields are junk and must be ignored
        t = cyc; base = obs.size();
        push(2'd3, data_t'('hD0));
        push(2'd2, data_t'('hD1));
        push(2'd1, data_t'('hD2));
        push(2'd3, data_t'('hD3));
        repeat (6) step();
        check("T2 beats", data_t'(obs.size() - base), data_t'(4));
        for (int k = 0; k < 4; k++) begin
            check("T2 data", obs[base+k].data, data_t'('hD0 + k));
            check("T2 cycle", data_t'(obs[base+k].cyc), data_t'(t + 1 + k));
            check("T2 sop", obs[base+k].sop, (k == 0));
            check("T2 eop", obs[base+k].eop, (k == 3));
        end
        check("T2 idle", idle, 1'b1);

        // almostFull rises just after the header; next header waits for af_q low
        t = cyc; base = obs.size();
        push(2'd3, data_t'('hE0));
        push(2'd0, data_t'('hE1));
        push(2'd0, data_t'('hE2));
        push(2'd0, data_t'('hE3));
        push(2'd0, data_t'('h77));
        step();
        bus.tx_almostFull = 1'b1;
        repeat (5) step();
        check("T3 held beats", data_t'(obs.size() - base), data_t'(4));
        t_drop = cyc;
        bus.tx_almostFull = 1'b0;
        repeat (5) step();
        check("T3 beats", data_t'(obs.size() - base), data_t'(5));
        check("T3 E3 eop", obs[base+3].eop, 1'b1);
        check("T3 E3 cycle", data_t'(obs[base+3].cyc), data_t'(t + 4));
        check("T3 next data", obs[base+4].data, data_t'('h77));
        check("T3 next cycle", data_t'(obs[base+4].cyc), data_t'(t_drop + 2));

        // Bubbles between body beats
        t = cyc; base = obs.size();
        push(2'd2, data_t'('hB0));
        repeat (3) step();
        check("T4 idle in gap", idle, 1'b0);
        push(2'd0, data_t'('hB1));
        repeat (3) step();
        push(2'd0, data_t'('hB2));
        repeat (4) step();
        check("T4 beats", data_t'(obs.size() - base), data_t'(3));
        check("T4 cycle 1", data_t'(obs[base+1].cyc), data_t'(t + 4));
        check("T4 cycle 2", data_t'(obs[base+2].cyc), data_t'(t + 7));
        check("T4 eop 1", obs[base+1].eop, 1'b0);
        check("T4 eop 2", obs[base+2].eop, 1'b1);
        check("T4 idle", idle, 1'b1);

        // Reset mid-packet; FIFO flushed in the same cycle
        t = cyc; base = obs.size();
        push(2'd3, data_t'('hC0));
        push(2'd0, data_t'('hC1));
        push(2'd0, data_t'('hC2));
        push(2'd0, data_t'('hC3));
        repeat (2) step();
        reset = 1'b1;
        fq.delete();
        drive_fifo();
        step();
        check("T5 valid after reset", bus.tx_valid, 1'b0);
        check("T5 idle after reset", idle, 1'b1);
        check("T5 beats before reset", data_t'(obs.size() - base), data_t'(2));
        reset = 1'b0;
        t = cyc; base = obs.size();
        push(2'd0, data_t'('h3C));
        repeat (4) step();
        check("T5 beats after", data_t'(obs.size() - base), data_t'(1));
        check("T5 data", obs[base].data, data_t'('h3C));
        check("T5 sop", obs[base].sop, 1'b1);
        check("T5 cycle", data_t'(obs[base].cyc), data_t'(t + 2));

        // Five packets plus seven backpressured cycles with work waiting
        reset = 1'b1;
        fq.delete();
        drive_fifo();
        repeat (2) step();
        reset = 1'b0;
        repeat (2) step();
        base = obs.size();
        for (int k = 0; k < 4; k++) push(2'd0, data_t'('h50 + k));
        repeat (6) step();
        bus.tx_almostFull = 1'b1;
        step();
        push(2'd1, data_t'('h60));
        push(2'd0, data_t'('h61));
        repeat (6) step();
        bus.tx_almostFull = 1'b0;
        repeat (6) step();
        check("T6 beats", data_t'(obs.size() - base), data_t'(6));
        check("T6 last eop", obs[base+5].eop, 1'b1);
`ifdef FIFO_DRAIN_TX_STATS_EN
        check("T6 stat_pkts", stat_pkts, 32'd5);
        check("T6 stat_stall_cycles", stat_stall_cycles, 32'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
